bin_to_bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter built on the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces the unrolled combinational add-3 chain used in the seven-segment display path for wide operands, supports optional two's-complement input, and exposes a start/busy/done handshake. It sits between the datapath result registers and the display digit multiplexer.

---
 rtl/bin_to_bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one operand bit per clock,
// with optional two's-complement input and a start/busy/done handshake.
`timescale 1ns/1ps
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter bit SIGNED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
   function automatic bit digits_fit();
      logic [WIDTH-1:0] v;
      v = '1;
      for (int i = 0; i < DIGITS; i++) v = v / WIDTH'(10);
      return (v == '0);
   endfunction

   if (!digits_fit()) begin : g_digits_too_few
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
   end

   function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] > 4'd4) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    sh_q, sh_d;
   logic [BW-1:0]       scr_q, scr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic                neg_q, neg_d;
   logic                done_q, done_d;

   logic signed [WIDTH-1:0] bin_s;
   logic signed [WIDTH-1:0] bin_neg;
   logic                    is_neg;
   logic [WIDTH-1:0]        mag;

   // Negating the most-negative value wraps back to 2^(WIDTH-1), which is the
   // correct magnitude when read as unsigned.
   assign bin_s   = bin;
   assign bin_neg = -bin_s;
   assign is_neg  = SIGNED && bin[WIDTH-1];
   assign mag     = is_neg ? bin_neg : bin;

   always_comb begin
      logic [BW-1:0]       adj;
      logic [BW+WIDTH-1:0] cat;
      state_d = state_q;
      sh_d    = sh_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      adj     = add3_digits(scr_q);
      cat     = {adj[BW-2:0], sh_q, 1'b0};
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = mag;
               sign_d  = is_neg;
               scr_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            scr_d = cat[BW+WIDTH-1:WIDTH];
            sh_d  = cat[WIDTH-1:0];
            if (cnt_q == '0) begin
               bcd_d   = cat[BW+WIDTH-1:WIDTH];
               neg_d   = sign_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign neg  = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (8-bit unsigned, 8-bit signed,
// 16-bit unsigned) checked against a decimal reference model.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_v [3];
   logic [15:0] bin_v   [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic [19:0] bcd_w   [3];
   logic        neg_w   [3];

   logic [11:0] bcd0, bcd1;
   logic [19:0] bcd2;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_u8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin_v[0][7:0]),
      .busy(busy_w[0]), .done(done_w[0]), .bcd(bcd0), .neg(neg_w[0]));
   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_s8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin_v[1][7:0]),
      .busy(busy_w[1]), .done(done_w[1]), .bcd(bcd1), .neg(neg_w[1]));
   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_u16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin_v[2]),
      .busy(busy_w[2]), .done(done_w[2]), .bcd(bcd2), .neg(neg_w[2]));

   assign bcd_w[0] = {8'h0, bcd0};
   assign bcd_w[1] = {8'h0, bcd1};
   assign bcd_w[2] = bcd2;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits of the magnitude by repeated division.
   task automatic model(input int s, input logic [15:0] v, output logic [19:0] b, output logic n);
      int val;
      n = 1'b0;
      if (s == 0) val = int'(v[7:0]);
      else if (s == 1) begin
         val = int'($signed(v[7:0]));
         if (val < 0) begin
            n   = 1'b1;
            val = -val;
         end
      end else val = int'(v);
      b = '0;
      for (int i = 0; i < 5; i++) begin
         b[4*i +: 4] = 4'(val % 10);
         val = val / 10;
      end
   endtask

   // Called at a negedge; asserts start there and returns at the done negedge.
   // glitch_at > 0 re-asserts start (bin=200) at that busy cycle.
   task automatic convert(input int s, input logic [15:0] v, input int glitch_at, input string tag);
      int          cyc, iter, w;
      logic [19:0] exp_b;
      logic        exp_n;
      w = (s == 2) ? 16 : 8;
      model(s, v, exp_b, exp_n);
      start_v[s] = 1'b1;
      bin_v[s]   = v;
      @(negedge clk);
      start_v[s] = 1'b0;
      bin_v[s]   = 16'($urandom);
      cyc  = 0;
      iter = 0;
      while (!done_w[s] && iter < 40) begin
         if (busy_w[s]) cyc++;
         if (glitch_at > 0 && cyc == glitch_at) begin
            start_v[s] = 1'b1;
            bin_v[s]   = 16'd200;
         end else start_v[s] = 1'b0;
         iter++;
         @(negedge clk);
      end
      start_v[s] = 1'b0;
      check_eq({tag, " done_seen"}, 32'(done_w[s]), 32'd1);
      check_eq({tag, " busy_cycles"}, 32'(cyc), 32'(w));
      check_eq({tag, " busy_at_done"}, 32'(busy_w[s]), 32'd0);
      check_eq({tag, " bcd"}, 32'(bcd_w[s]), 32'(exp_b));
      check_eq({tag, " neg"}, 32'(neg_w[s]), 32'(exp_n));
   endtask

   task automatic expect_quiet(input int s, input int ncyc, input string tag);
      int seen_b, seen_d;
      seen_b = 0;
      seen_d = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (busy_w[s]) seen_b++;
         if (done_w[s]) seen_d++;
      end
      check_eq({tag, " busy_count"}, 32'(seen_b), 32'd0);
      check_eq({tag, " done_count"}, 32'(seen_d), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         bin_v[i]   = '0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         check_eq("rst busy", 32'(busy_w[i]), 32'd0);
         check_eq("rst done", 32'(done_w[i]), 32'd0);
         check_eq("rst bcd", 32'(bcd_w[i]), 32'd0);
         check_eq("rst neg", 32'(neg_w[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet(0, 5, "idle");
      check_eq("idle bcd", 32'(bcd_w[0]), 32'd0);

      convert(0, 16'd255, 0, "u8 255");
      @(negedge clk);
      check_eq("done one cycle", 32'(done_w[0]), 32'd0);
      convert(0, 16'd99, 0, "u8 99");
      @(negedge clk);
      convert(0, 16'd0, 0, "u8 0");
      @(negedge clk);

      convert(0, 16'd37, 3, "u8 37 ignore start");
      expect_quiet(0, 12, "no queued start");
      convert(0, 16'd99, 0, "u8 99 pre b2b");
      convert(0, 16'd200, 0, "u8 200 b2b");
      @(negedge clk);

      convert(1, 16'h0080, 0, "s8 80");
      convert(1, 16'h00FF, 0, "s8 FF");
      convert(1, 16'h007F, 0, "s8 7F");
      convert(1, 16'h0000, 0, "s8 0");
      @(negedge clk);

      convert(2, 16'd65535, 0, "u16 65535");
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         convert(0, 16'($urandom_range(0, 255)), 0, "u8 rand");
         convert(1, 16'($urandom_range(0, 255)), 0, "s8 rand");
         convert(2, 16'($urandom), 0, "u16 rand");
      end

      // Abort mid-conversion with a half-cycle reset pulse.
      @(negedge clk);
      convert(0, 16'd255, 0, "u8 pre abort");
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 16'd123;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("abort busy before", 32'(busy_w[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort busy", 32'(busy_w[0]), 32'd0);
      check_eq("abort done", 32'(done_w[0]), 32'd0);
      check_eq("abort bcd", 32'(bcd_w[0]), 32'd0);
      check_eq("abort neg", 32'(neg_w[0]), 32'd0);
      #3;
      rst_n = 1'b1;
      expect_quiet(0, 12, "after abort");
      check_eq("after abort bcd", 32'(bcd_w[0]), 32'd0);
      convert(0, 16'd42, 0, "u8 42 after abort");
      @(negedge clk);
      convert(1, 16'h00C8, 0, "s8 C8 after abort");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
